mem_wb_skid: RTL and testbench
==============================

MEM_WB_SKID -- requirements
Module: mem_wb_skid

Interface
REQ-001 Parameter DATA_W, default 32: datapath width in bits; SHALL be a multiple of 8, minimum 32.
REQ-002 Parameter RD_W, default 5: destination register index width.
REQ-003 Parameter BE_W, default DATA_W/8: byte-enable width; derived, SHALL NOT be overridden.
REQ-004 clk  in  1  clock; all state SHALL update on the falling edge of clk, as for every pipeline register in this core.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Flush  in  1  discard all buffered entries (exception/redirect).
REQ-007 in_valid  in  1  MEM stage presents an entry.
REQ-008 in_ready  out  1  block can accept an entry this edge.
REQ-009 ALU_in  in  DATA_W  ALU/shifter result.
REQ-010 Data_in  in  DATA_W  raw memory read word.
REQ-011 BE_in  in  BE_W  load byte enables.
REQ-012 Signed_in  in  1  1 = sign-extend load, 0 = zero-extend.
REQ-013 Overflow_in, RegWr_in, MemtoReg_in  in  1 each  MEM-stage control bits.
REQ-014 Rd_in  in  RD_W  destination register.
REQ-015 out_valid  out  1  WB entry valid.
REQ-016 out_ready  in  1  WB/register file consumes the entry.
REQ-017 WbData_out  out  DATA_W  final write-back value.
REQ-018 RegWr_out  out  1  qualified register-file write enable.
REQ-019 Rd_out  out  RD_W  destination register.
REQ-020 Overflow_out  out  1  overflow flag forwarded to exception logic.

Function
REQ-021 Storage SHALL be exactly two entries: main (drives outputs) and skid; each holds valid, WbData, RegWr, Rd, Overflow.
REQ-022 in_ready SHALL equal NOT skid.valid and SHALL be a registered value.
REQ-023 Accept = in_valid AND in_ready; consume = out_valid AND out_ready, both sampled at the falling edge.
REQ-024 Main empty, or consume: main SHALL load skid if skid valid, else the accepted entry, else become empty; an accepted entry SHALL go to skid when skid drains into main in the same edge.
REQ-025 Main full, no consume, accept: the entry SHALL go to skid; main SHALL hold.
REQ-026 Latency SHALL be one edge: an entry accepted into an empty block SHALL appear on outputs immediately after that edge.
REQ-027 Ordering SHALL be FIFO; no entry SHALL be dropped or duplicated except by Flush/Reset.
REQ-028 Load merge (computed before storage): k = index of lowest set bit of BE_in, L = run length of contiguous set bits from k.
REQ-029 If L is 1, 2 or 4 and no other bits are set, loaded value = Data_in[8k +: 8L], sign- or zero-extended to DATA_W per Signed_in; any other non-zero BE_in SHALL pass Data_in unchanged.
REQ-030 WbData SHALL be the loaded value when MemtoReg_in=1, else ALU_in.
REQ-031 Stored RegWr = RegWr_in AND NOT Overflow_in AND (Rd_in != 0) AND NOT (MemtoReg_in AND BE_in == 0).
REQ-032 RegWr_out SHALL be stored RegWr AND out_valid; with out_valid=0 the other data outputs SHALL hold their last values.
REQ-033 Flush SHALL clear both valids and set in_ready=1 at that edge; Flush SHALL override a simultaneous accept or consume.

Reset
REQ-034 Reset SHALL take priority over Flush, clearing both entries and driving out_valid, RegWr_out, Overflow_out, WbData_out and Rd_out to 0, and in_ready to 1 at that edge.
REQ-035 Reset asserted mid-stall SHALL discard both buffered entries; no write SHALL be issued afterwards for them.

Verification
REQ-036 ALU_in=0x00000005, MemtoReg=0, RegWr=1, Rd=3, out_ready=1 -> next edge out_valid=1, WbData_out=0x00000005, RegWr_out=1, Rd_out=3.
REQ-037 Data_in=0x12345680, BE=0010, Signed=1, MemtoReg=1 -> WbData_out=0x00000056; BE=0001 Signed=1 -> 0xFFFFFF80; Signed=0 -> 0x00000080.
REQ-038 out_ready=0, three back-to-back entries A,B,C -> A in main, B in skid, in_ready=0, C held upstream; out_ready=1 -> A,B,C emerge in order, one per edge.
REQ-039 Overflow_in=1 with RegWr_in=1 -> RegWr_out=0, Overflow_out=1; Rd_in=0 with RegWr_in=1 -> RegWr_out=0.
REQ-040 Both entries full, Flush=1 with in_valid=1 -> next edge out_valid=0, in_ready=1, new entry not captured.
REQ-041 Reset=1 and Flush=1 asserted together while both entries are full -> all outputs 0, in_ready=1.

Source files
------------

// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline register: merges load data, qualifies the register write, buffers two entries.
// Latency: one falling edge from accept to outputs; main entry drives the WB outputs.
// Backpressure: in_ready is registered and drops only while the skid entry is occupied.
module mem_wb_skid #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ALU_in,
    input  logic [DATA_W-1:0] Data_in,
    input  logic [BE_W-1:0]   BE_in,
    input  logic              Signed_in,
    input  logic              Overflow_in,
    input  logic              RegWr_in,
    input  logic              MemtoReg_in,
    input  logic [RD_W-1:0]   Rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] WbData_out,
    output logic              RegWr_out,
    output logic [RD_W-1:0]   Rd_out,
    output logic              Overflow_out
);

    // Wide enough to hold a byte-lane index and a run length up to BE_W.
    localparam int IDX_W = $clog2(BE_W) + 1;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] wb;
        logic              regwr;
        logic [RD_W-1:0]   rd;
        logic              ovf;
    } ent_t;

    ent_t main_q, main_d;
    ent_t skid_q, skid_d;
    ent_t new_ent;
    logic in_ready_q, in_ready_d;

    logic              accept;
    logic              consume;

    logic [IDX_W-1:0]  lo_idx;
    logic              lo_found;
    logic [IDX_W-1:0]  run_len;
    logic              run_open;
    logic [BE_W-1:0]   be_sh;
    logic              extra_bits;
    logic              natural_size;
    logic [DATA_W-1:0] data_sh;
    logic              sign_bit;
    logic [DATA_W-1:0] load_val;

    // Load merge: locate the enabled byte run, extract it and extend to full width.
    always_comb begin
        lo_idx   = '0;
        lo_found = 1'b0;
        for (int i = 0; i < BE_W; i++) begin
            if (!lo_found && BE_in[i]) begin
                lo_idx   = IDX_W'(i);
                lo_found = 1'b1;
            end
        end
        be_sh    = BE_in >> lo_idx;
        run_len  = '0;
        run_open = 1'b1;
        for (int i = 0; i < BE_W; i++) begin
            if (run_open && be_sh[i]) begin
                run_len = run_len + IDX_W'(1);
            end else begin
                run_open = 1'b0;
            end
        end
        // Any enabled byte beyond the first run makes this an irregular access.
        extra_bits   = (be_sh >> run_len) != '0;
        natural_size = !extra_bits &&
                       (run_len == IDX_W'(1) || run_len == IDX_W'(2) || run_len == IDX_W'(4));
        data_sh = Data_in >> {lo_idx, 3'b000};
        case (run_len)
            IDX_W'(1): sign_bit = data_sh[7];
            IDX_W'(2): sign_bit = data_sh[15];
            default:   sign_bit = data_sh[31];
        endcase
        load_val = Data_in;
        if (natural_size) begin
            for (int i = 0; i < DATA_W; i++) begin
                load_val[i] = (i < 8 * int'(run_len)) ? data_sh[i] : (Signed_in & sign_bit);
            end
        end
    end

    // Build the entry as it will be stored: write-back value and qualified write enable.
    always_comb begin
        new_ent.vld   = 1'b1;
        new_ent.wb    = MemtoReg_in ? load_val : ALU_in;
        new_ent.regwr = RegWr_in & ~Overflow_in & (Rd_in != '0) & ~(MemtoReg_in & (BE_in == '0));
        new_ent.rd    = Rd_in;
        new_ent.ovf   = Overflow_in;
    end

    assign accept  = in_valid & in_ready_q;
    assign consume = main_q.vld & out_ready;

    // Two-entry skid control: main refills from skid first to keep FIFO order.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (Flush) begin
            main_d.vld = 1'b0;
            skid_d.vld = 1'b0;
        end else if (!main_q.vld || consume) begin
            if (skid_q.vld) begin
                main_d = skid_q;
                if (accept) begin
                    skid_d = new_ent;
                end else begin
                    skid_d.vld = 1'b0;
                end
            end else if (accept) begin
                main_d = new_ent;
            end else begin
                // Payload is kept so outputs hold their last value while idle.
                main_d.vld = 1'b0;
            end
        end else if (accept) begin
            skid_d = new_ent;
        end
        in_ready_d = ~skid_d.vld;
    end

    // Pipeline state advances on the falling edge, like the rest of the core.
    always_ff @(negedge clk) begin
        if (Reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = main_q.vld;
    assign WbData_out   = main_q.wb;
    assign RegWr_out    = main_q.regwr & main_q.vld;
    assign Rd_out       = main_q.rd;
    assign Overflow_out = main_q.ovf;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed bench for mem_wb_skid: table of per-edge vectors plus streaming and reset-mid-stall sequences.
module tb_mem_wb_skid;

    typedef logic [31:0] w_t;

    typedef struct {
        w_t rst, fl, iv, alu, dat, be, sg, ov, rw, m2r, rd, ordy;
        w_t e_vld, e_rdy, e_wb, e_rw, e_rd, e_ov, wb_dc;
    } vec_t;

    logic        clk = 1'b0;
    logic        Reset = 1'b0, Flush = 1'b0, in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ALU_in = '0, Data_in = '0;
    logic [3:0]  BE_in = '0;
    logic        Signed_in = 1'b0, Overflow_in = 1'b0, RegWr_in = 1'b0, MemtoReg_in = 1'b0;
    logic [4:0]  Rd_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] WbData_out;
    logic        RegWr_out;
    logic [4:0]  Rd_out;
    logic        Overflow_out;

    int n_vec = 0;
    int n_err = 0;
    vec_t vq[$];

    mem_wb_skid dut (
        .clk(clk), .Reset(Reset), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALU_in(ALU_in), .Data_in(Data_in), .BE_in(BE_in), .Signed_in(Signed_in),
        .Overflow_in(Overflow_in), .RegWr_in(RegWr_in), .MemtoReg_in(MemtoReg_in), .Rd_in(Rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .WbData_out(WbData_out), .RegWr_out(RegWr_out), .Rd_out(Rd_out), .Overflow_out(Overflow_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input w_t act, input w_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Reset = 1'b0; Flush = 1'b0; in_valid = 1'b0; ALU_in = '0; Data_in = '0; BE_in = '0;
        Signed_in = 1'b0; Overflow_in = 1'b0; RegWr_in = 1'b0; MemtoReg_in = 1'b0; Rd_in = '0;
    endtask

    task automatic drive(input vec_t v);
        Reset = v.rst[0]; Flush = v.fl[0]; in_valid = v.iv[0]; ALU_in = v.alu; Data_in = v.dat;
        BE_in = v.be[3:0]; Signed_in = v.sg[0]; Overflow_in = v.ov[0]; RegWr_in = v.rw[0];
        MemtoReg_in = v.m2r[0]; Rd_in = v.rd[4:0]; out_ready = v.ordy[0];
    endtask

    // Push an ALU (non-load) entry onto the bus for one cycle.
    task automatic put_alu(input w_t val, input w_t rd, input logic ordy);
        idle_inputs();
        in_valid = 1'b1; ALU_in = val; RegWr_in = 1'b1; Rd_in = rd[4:0]; out_ready = ordy;
    endtask

    initial begin
        //                rst fl iv alu           dat           be    sg ov rw m2r rd ordy | vld rdy wb          rw rd ov dc
        vq.push_back(vec_t'{1, 0, 0, 0,           0,            0,    0, 0, 0, 0,  0, 0,   0, 1, 0,           0, 0, 0, 0}); // reset
        vq.push_back(vec_t'{0, 0, 1, 'h5,         0,            0,    0, 0, 1, 0,  3, 1,   1, 1, 'h5,         1, 3, 0, 0}); // alu result
        vq.push_back(vec_t'{0, 0, 1, 0,           'h12345680,   'h2,  1, 0, 1, 1,  4, 1,   1, 1, 'h56,        1, 4, 0, 0}); // byte 1
        vq.push_back(vec_t'{0, 0, 1, 0,           'h12345680,   'h1,  1, 0, 1, 1,  5, 1,   1, 1, 'hFFFFFF80,  1, 5, 0, 0}); // sext byte
        vq.push_back(vec_t'{0, 0, 1, 0,           'h12345680,   'h1,  0, 0, 1, 1,  6, 1,   1, 1, 'h80,        1, 6, 0, 0}); // zext byte
        vq.push_back(vec_t'{0, 0, 1, 0,           'h80011234,   'hC,  1, 0, 1, 1,  7, 1,   1, 1, 'hFFFF8001,  1, 7, 0, 0}); // upper half
        vq.push_back(vec_t'{0, 0, 1, 0,           'h00C3D211,   'h6,  1, 0, 1, 1,  8, 1,   1, 1, 'hFFFFC3D2,  1, 8, 0, 0}); // mid half
        vq.push_back(vec_t'{0, 0, 1, 0,           'h9A000000,   'h8,  1, 0, 1, 1,  9, 1,   1, 1, 'hFFFFFF9A,  1, 9, 0, 0}); // byte 3
        vq.push_back(vec_t'{0, 0, 1, 0,           'h87654321,   'hF,  1, 0, 1, 1, 10, 1,   1, 1, 'h87654321,  1,10, 0, 0}); // word
        vq.push_back(vec_t'{0, 0, 1, 0,           'hAABBCCDD,   'h5,  1, 0, 1, 1, 11, 1,   1, 1, 'hAABBCCDD,  1,11, 0, 0}); // gap -> raw
        vq.push_back(vec_t'{0, 0, 1, 0,           'h00F0F0F0,   'h7,  1, 0, 1, 1, 12, 1,   1, 1, 'h00F0F0F0,  1,12, 0, 0}); // 3 bytes -> raw
        vq.push_back(vec_t'{0, 0, 1, 0,           'h11111111,   'h0,  0, 0, 1, 1, 13, 1,   1, 1, 0,           0,13, 0, 1}); // load, BE=0
        vq.push_back(vec_t'{0, 0, 1, 'h7FFFFFFF,  0,            0,    0, 1, 1, 0, 14, 1,   1, 1, 'h7FFFFFFF,  0,14, 1, 0}); // overflow
        vq.push_back(vec_t'{0, 0, 1, 'h22,        0,            0,    0, 0, 1, 0,  0, 1,   1, 1, 'h22,        0, 0, 0, 0}); // rd zero
        vq.push_back(vec_t'{0, 0, 1, 'h33,        'hDEADBEEF,   'h3,  1, 0, 1, 0, 15, 1,   1, 1, 'h33,        1,15, 0, 0}); // alu select
        vq.push_back(vec_t'{0, 0, 0, 0,           0,            0,    0, 0, 0, 0,  0, 1,   0, 1, 'h33,        0,15, 0, 0}); // drain, hold
        vq.push_back(vec_t'{0, 0, 1, 'hA,         0,            0,    0, 0, 1, 0, 16, 0,   1, 1, 'hA,         1,16, 0, 0}); // A -> main
        vq.push_back(vec_t'{0, 0, 1, 'hB,         0,            0,    0, 0, 1, 0, 17, 0,   1, 0, 'hA,         1,16, 0, 0}); // B -> skid
        vq.push_back(vec_t'{0, 0, 1, 'hC,         0,            0,    0, 0, 1, 0, 18, 0,   1, 0, 'hA,         1,16, 0, 0}); // C held
        vq.push_back(vec_t'{0, 0, 1, 'hC,         0,            0,    0, 0, 1, 0, 18, 1,   1, 1, 'hB,         1,17, 0, 0}); // B out
        vq.push_back(vec_t'{0, 0, 1, 'hC,         0,            0,    0, 0, 1, 0, 18, 1,   1, 1, 'hC,         1,18, 0, 0}); // C out
        vq.push_back(vec_t'{0, 0, 0, 0,           0,            0,    0, 0, 0, 0,  0, 1,   0, 1, 'hC,         0,18, 0, 0}); // empty
        vq.push_back(vec_t'{0, 0, 1, 'hD,         0,            0,    0, 0, 1, 0, 19, 0,   1, 1, 'hD,         1,19, 0, 0}); // D main
        vq.push_back(vec_t'{0, 0, 1, 'hE,         0,            0,    0, 0, 1, 0, 20, 0,   1, 0, 'hD,         1,19, 0, 0}); // E skid
        vq.push_back(vec_t'{0, 1, 1, 'hF,         0,            0,    0, 0, 1, 0, 21, 1,   0, 1, 'hD,         0,19, 0, 0}); // flush full
        vq.push_back(vec_t'{0, 0, 0, 0,           0,            0,    0, 0, 0, 0,  0, 1,   0, 1, 'hD,         0,19, 0, 0}); // nothing left
        vq.push_back(vec_t'{0, 0, 1, 'h10,        0,            0,    0, 0, 1, 0, 22, 0,   1, 1, 'h10,        1,22, 0, 0}); // G main
        vq.push_back(vec_t'{0, 1, 1, 'h11,        0,            0,    0, 0, 1, 0, 23, 1,   0, 1, 'h10,        0,22, 0, 0}); // flush beats accept
        vq.push_back(vec_t'{0, 0, 0, 0,           0,            0,    0, 0, 0, 0,  0, 1,   0, 1, 'h10,        0,22, 0, 0}); // nothing left
        vq.push_back(vec_t'{0, 0, 1, 'h20,        0,            0,    0, 1, 1, 0, 24, 0,   1, 1, 'h20,        0,24, 1, 0}); // H ovf main
        vq.push_back(vec_t'{0, 0, 1, 'h21,        0,            0,    0, 0, 1, 0, 25, 0,   1, 0, 'h20,        0,24, 1, 0}); // I skid
        vq.push_back(vec_t'{1, 1, 1, 'h30,        0,            0,    0, 0, 1, 0, 26, 1,   0, 1, 0,           0, 0, 0, 0}); // reset+flush
        vq.push_back(vec_t'{0, 0, 0, 0,           0,            0,    0, 0, 0, 0,  0, 1,   0, 1, 0,           0, 0, 0, 0}); // stays empty

        // Inputs change just after the rising edge; outputs are checked after the falling edge.
        foreach (vq[i]) begin
            @(posedge clk);
            drive(vq[i]);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d.out_valid", i), w_t'(out_valid), vq[i].e_vld);
            chk($sformatf("v%0d.in_ready", i), w_t'(in_ready), vq[i].e_rdy);
            if (vq[i].wb_dc == 0) chk($sformatf("v%0d.WbData_out", i), WbData_out, vq[i].e_wb);
            chk($sformatf("v%0d.RegWr_out", i), w_t'(RegWr_out), vq[i].e_rw);
            chk($sformatf("v%0d.Rd_out", i), w_t'(Rd_out), vq[i].e_rd);
            chk($sformatf("v%0d.Overflow_out", i), w_t'(Overflow_out), vq[i].e_ov);
        end

        // Streaming with an irregular out_ready pattern: 20 entries must emerge in order.
        begin
            int sent = 0;
            int recv = 0;
            int cyc  = 0;
            logic [15:0] pat = 16'b1011_0010_1100_0101;
            while (recv < 20 && cyc < 400) begin
                @(posedge clk);
                #1;
                idle_inputs();
                out_ready = pat[cyc % 16];
                if (sent < 20) begin
                    in_valid = 1'b1; ALU_in = 32'h100 + w_t'(sent); RegWr_in = 1'b1; Rd_in = 5'd1;
                end
                if (out_valid && out_ready) begin
                    chk($sformatf("stream%0d.WbData_out", recv), WbData_out, 32'h100 + w_t'(recv));
                    chk($sformatf("stream%0d.RegWr_out", recv), w_t'(RegWr_out), 1);
                    recv++;
                end
                if (in_valid && in_ready) sent++;
                cyc++;
            end
            chk("stream.received", w_t'(recv), 20);
        end

        // Reset while stalled with both entries full: nothing may be written afterwards.
        @(posedge clk); #1; put_alu(32'h55, 7, 1'b0);
        @(posedge clk); #1;
        chk("midrst.pre_valid", w_t'(out_valid), 1);
        put_alu(32'h66, 8, 1'b0);
        @(posedge clk); #1;
        chk("midrst.pre_in_ready", w_t'(in_ready), 0);
        idle_inputs(); Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst%0d.out_valid", k), w_t'(out_valid), 0);
            chk($sformatf("midrst%0d.RegWr_out", k), w_t'(RegWr_out), 0);
            chk($sformatf("midrst%0d.in_ready", k), w_t'(in_ready), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
